// File: rtl/cycle_sequencer.sv
// cycle_sequencer: per-instruction bus-cycle state machine for the 6502 core.
// Rev 1.0 - initial release.
`default_nettype none

module cycle_sequencer #(
  parameter int PAGE_PENALTY = 1,
  parameter int JAM_HALT     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [4:0] op_type,
  input  logic       is_store,
  input  logic       is_rmw,
  input  logic       page_cross,
  input  logic       stack_done,
  output logic       sync,
  output logic       ir_load,
  output logic       pc_inc,
  output logic [2:0] addr_sel,
  output logic       adl_load,
  output logic       adh_load,
  output logic       idx_add,
  output logic       rw,
  output logic       exec,
  output logic       stack_req,
  output logic       jam
);

  localparam logic [4:0] OP_IMP = 5'd0;
  localparam logic [4:0] OP_IMM = 5'd1;
  localparam logic [4:0] OP_ZPG = 5'd2;
  localparam logic [4:0] OP_ZXY = 5'd3;
  localparam logic [4:0] OP_ABS = 5'd4;
  localparam logic [4:0] OP_AXY = 5'd5;
  localparam logic [4:0] OP_XIN = 5'd6;
  localparam logic [4:0] OP_INY = 5'd7;
  localparam logic [4:0] OP_JUM = 5'd8;
  localparam logic [4:0] OP_JIN = 5'd9;
  localparam logic [4:0] OP_BNT = 5'd10;
  localparam logic [4:0] OP_BRA = 5'd11;
  localparam logic [4:0] OP_BRK = 5'd12;
  localparam logic [4:0] OP_PUL = 5'd17;
  localparam logic [4:0] OP_JAM = 5'd18;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,  S_OPL = 4'd1,  S_OPH = 4'd2,  S_IDX   = 4'd3,
    S_PTRL  = 4'd4,  S_PTRH = 4'd5, S_FIX = 4'd6,  S_RD    = 4'd7,
    S_MOD   = 4'd8,  S_WR  = 4'd9,  S_BR  = 4'd10, S_BRFIX = 4'd11,
    S_STK   = 4'd12, S_JAM = 4'd13
  } state_t;

  state_t     r_state;
  logic [4:0] r_op;
  logic       r_store;
  logic       r_rmw;
  logic       r_exec_pend;

  logic [4:0] w_op_in;
  logic       w_op_stack;
  logic       w_go;
  logic [2:0] w_final_sel;
  state_t     w_mem_state;
  state_t     w_idx_state;

  // Unknown codes and non-halting JAM collapse onto IMP before being latched.
  always_comb begin
    w_op_in = op_type;
    if (op_type > OP_JAM || (op_type == OP_JAM && JAM_HALT == 0))
      w_op_in = OP_IMP;
  end

  assign w_op_stack  = (w_op_in >= OP_BRK) && (w_op_in <= OP_PUL);
  assign w_go        = rdy & ~rst;
  assign w_final_sel = (r_op == OP_ZPG || r_op == OP_ZXY) ? 3'd1 : 3'd2;
  assign w_mem_state = r_store ? S_WR : S_RD;
  // Writes never speculate on the indexed address, so store/RMW always fix up.
  assign w_idx_state = (r_store || r_rmw || (page_cross && (PAGE_PENALTY != 0)))
                       ? S_FIX : w_mem_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_op        <= OP_IMP;
      r_store     <= 1'b0;
      r_rmw       <= 1'b0;
      r_exec_pend <= 1'b0;
    end else if (rdy) begin
      case (r_state)
        S_FETCH: begin
          r_op        <= w_op_in;
          r_store     <= is_store;
          r_rmw       <= is_rmw;
          r_exec_pend <= 1'b0;
          if (w_op_stack)              r_state <= S_STK;
          else if (w_op_in == OP_JAM)  r_state <= S_JAM;
          else                         r_state <= S_OPL;
        end
        S_OPL: begin
          case (r_op)
            OP_IMP, OP_IMM: begin
              r_state     <= S_FETCH;
              r_exec_pend <= 1'b1;
            end
            OP_ZPG:                         r_state <= w_mem_state;
            OP_ZXY, OP_XIN:                 r_state <= S_IDX;
            OP_ABS, OP_AXY, OP_JUM, OP_JIN: r_state <= S_OPH;
            OP_INY:                         r_state <= S_PTRL;
            OP_BRA:                         r_state <= S_BR;
            default:                        r_state <= S_FETCH;
          endcase
        end
        S_IDX:  r_state <= (r_op == OP_XIN) ? S_PTRL : w_mem_state;
        S_OPH: begin
          case (r_op)
            OP_AXY:  r_state <= w_idx_state;
            OP_JIN:  r_state <= S_PTRL;
            OP_JUM:  r_state <= S_FETCH;
            default: r_state <= w_mem_state;
          endcase
        end
        S_PTRL: r_state <= S_PTRH;
        S_PTRH: begin
          case (r_op)
            OP_INY:  r_state <= w_idx_state;
            OP_XIN:  r_state <= w_mem_state;
            default: r_state <= S_FETCH;
          endcase
        end
        S_FIX:   r_state <= w_mem_state;
        S_RD:    r_state <= r_rmw ? S_MOD : S_FETCH;
        S_MOD:   r_state <= S_WR;
        S_WR:    r_state <= S_FETCH;
        S_BR:    r_state <= (page_cross && (PAGE_PENALTY != 0)) ? S_BRFIX : S_FETCH;
        S_BRFIX: r_state <= S_FETCH;
        S_STK:   if (stack_done) r_state <= S_FETCH;
        S_JAM:   r_state <= S_JAM;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    sync      = (r_state == S_FETCH);
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    addr_sel  = 3'd0;
    adl_load  = 1'b0;
    adh_load  = 1'b0;
    idx_add   = 1'b0;
    rw        = 1'b1;
    exec      = 1'b0;
    stack_req = (r_state == S_STK) && !rst;
    jam       = (r_state == S_JAM) && !rst;
    case (r_state)
      S_FETCH: begin
        ir_load = w_go;
        pc_inc  = w_go;
        exec    = w_go & r_exec_pend;
      end
      S_OPL: begin
        pc_inc   = w_go & (r_op != OP_IMP);
        adl_load = w_go & (r_op != OP_IMP) & (r_op != OP_IMM)
                        & (r_op != OP_BNT) & (r_op != OP_BRA);
      end
      S_OPH: begin
        pc_inc   = w_go;
        adh_load = w_go;
        idx_add  = w_go & (r_op == OP_AXY);
      end
      S_IDX: begin
        addr_sel = 3'd1;
        idx_add  = w_go;
      end
      S_PTRL: begin
        addr_sel = (r_op == OP_JIN) ? 3'd2 : 3'd3;
        adl_load = w_go;
      end
      S_PTRH: begin
        addr_sel = 3'd4;
        adh_load = w_go;
        idx_add  = w_go & (r_op == OP_INY);
      end
      S_FIX: addr_sel = 3'd2;
      S_RD: begin
        addr_sel = w_final_sel;
        exec     = w_go & ~r_rmw & ~r_store;
      end
      S_MOD: begin
        addr_sel = w_final_sel;
        rw       = 1'b0;
      end
      S_WR: begin
        addr_sel = w_final_sel;
        rw       = 1'b0;
        exec     = w_go & r_rmw;
      end
      default: ;
    endcase
    if (rst) begin
      addr_sel = 3'd0;
      rw       = 1'b1;
    end
  end

endmodule

`default_nettype wire
